// File: rtl/ysyx_22040386_pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stage-enable sequencer.
interface ysyx_22040386_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 64
);
    logic             i_CTL_if_valid;
    logic             i_CTL_load_use;
    logic             i_CTL_redirect;
    logic             i_CTL_mem_req;
    logic             i_CTL_mem_ready;
    logic             i_CTL_ebreak;
    logic             o_CTL_pc_en;
    logic             o_CTL_ifid_en;
    logic             o_CTL_ifid_flush;
    logic             o_CTL_idex_en;
    logic             o_CTL_idex_flush;
    logic             o_CTL_exmem_en;
    logic             o_CTL_memwb_en;
    logic             o_CTL_halted;
    logic             o_CTL_mem_err;
    logic [CNT_W-1:0] o_CTL_cycle_cnt;
    logic [CNT_W-1:0] o_CTL_stall_cnt;
    logic [CNT_W-1:0] o_CTL_flush_cnt;

    modport master (
        output i_CTL_if_valid, i_CTL_load_use, i_CTL_redirect,
               i_CTL_mem_req, i_CTL_mem_ready, i_CTL_ebreak,
        input  o_CTL_pc_en, o_CTL_ifid_en, o_CTL_ifid_flush, o_CTL_idex_en,
               o_CTL_idex_flush, o_CTL_exmem_en, o_CTL_memwb_en, o_CTL_halted,
               o_CTL_mem_err, o_CTL_cycle_cnt, o_CTL_stall_cnt, o_CTL_flush_cnt
    );

    modport slave (
        input  i_CTL_if_valid, i_CTL_load_use, i_CTL_redirect,
               i_CTL_mem_req, i_CTL_mem_ready, i_CTL_ebreak,
        output o_CTL_pc_en, o_CTL_ifid_en, o_CTL_ifid_flush, o_CTL_idex_en,
               o_CTL_idex_flush, o_CTL_exmem_en, o_CTL_memwb_en, o_CTL_halted,
               o_CTL_mem_err, o_CTL_cycle_cnt, o_CTL_stall_cnt, o_CTL_flush_cnt
    );
endinterface

// File: rtl/ysyx_22040386_pipe_ctrl.sv
// 5-stage pipeline stage-enable/flush sequencer with boot bubble, memory-wait
// timeout, ebreak halt and performance counters.
module ysyx_22040386_pipe_ctrl #(
    parameter int unsigned CNT_W       = 64,
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input logic                      i_CTL_clk,
    input logic                      i_CTL_rst_n,
    ysyx_22040386_pipe_ctrl_if.slave ctl
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              halted_q, halted_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
    logic exmem_en_c, memwb_en_c;
    logic mem_stall_c, timeout_c;

    always_ff @(posedge i_CTL_clk or negedge i_CTL_rst_n) begin
        if (!i_CTL_rst_n) begin
            state_q     <= S_BOOT;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Strobe decode, next state and counter updates.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        halted_d     = halted_q;
        mem_err_d    = mem_err_q;
        cycle_cnt_d  = cycle_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b0;
        memwb_en_c   = 1'b0;
        mem_stall_c  = ctl.i_CTL_mem_req & ~ctl.i_CTL_mem_ready;
        timeout_c    = 1'b0;

        case (state_q)
            S_BOOT: begin
                ifid_en_c    = 1'b1;
                ifid_flush_c = 1'b1;
                idex_en_c    = 1'b1;
                idex_flush_c = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
                state_d      = S_RUN;
            end
            S_RUN, S_WAIT: begin
                if (mem_stall_c) begin
                    pc_en_c = 1'b0;
                end else if (ctl.i_CTL_redirect) begin
                    pc_en_c      = 1'b1;
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    idex_en_c    = 1'b1;
                    idex_flush_c = 1'b1;
                    exmem_en_c   = 1'b1;
                    memwb_en_c   = 1'b1;
                    flush_cnt_d  = flush_cnt_q + CNT_W'(1);
                end else if (ctl.i_CTL_load_use) begin
                    idex_en_c    = 1'b1;
                    idex_flush_c = 1'b1;
                    exmem_en_c   = 1'b1;
                    memwb_en_c   = 1'b1;
                end else if (!ctl.i_CTL_if_valid) begin
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    idex_en_c    = 1'b1;
                    exmem_en_c   = 1'b1;
                    memwb_en_c   = 1'b1;
                end else begin
                    pc_en_c    = 1'b1;
                    ifid_en_c  = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    memwb_en_c = 1'b1;
                end

                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (!pc_en_c) stall_cnt_d = stall_cnt_q + CNT_W'(1);

                if (state_q == S_WAIT) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    timeout_c  = mem_stall_c && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
                end

                if (ctl.i_CTL_ebreak || timeout_c) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    mem_err_d = mem_err_q | timeout_c;
                end else if (mem_stall_c) begin
                    if (state_q == S_RUN) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end
        endcase
    end

    assign ctl.o_CTL_pc_en      = pc_en_c;
    assign ctl.o_CTL_ifid_en    = ifid_en_c;
    assign ctl.o_CTL_ifid_flush = ifid_flush_c;
    assign ctl.o_CTL_idex_en    = idex_en_c;
    assign ctl.o_CTL_idex_flush = idex_flush_c;
    assign ctl.o_CTL_exmem_en   = exmem_en_c;
    assign ctl.o_CTL_memwb_en   = memwb_en_c;
    assign ctl.o_CTL_halted     = halted_q;
    assign ctl.o_CTL_mem_err    = mem_err_q;
    assign ctl.o_CTL_cycle_cnt  = cycle_cnt_q;
    assign ctl.o_CTL_stall_cnt  = stall_cnt_q;
    assign ctl.o_CTL_flush_cnt  = flush_cnt_q;
endmodule
